// File: rtl/lfsr_prbs_checker_if.sv
// Serial PRBS stream bundle: one qualified bit per clock from the LFSR generator
// to the checker.
interface lfsr_prbs_checker_if;
    logic bit_valid;
    logic bit_in;

    modport master (output bit_valid, output bit_in);
    modport slave  (input  bit_valid, input  bit_in);
endinterface

// File: rtl/lfsr_prbs_checker.sv
// PRBS receive checker: self-synchronises to an LFSR bit stream using the
// generator's taps, then free-runs a local reference and counts bits/errors.
module lfsr_prbs_checker #(
    parameter int WIDTH       = 8,
    parameter int LOCK_COUNT  = 16,
    parameter int UNLOCK_ERRS = 4,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    lfsr_prbs_checker_if.slave   rx,
    input  logic [WIDTH-1:0]     tap_pattern,
    input  logic                 resync,
    input  logic                 clear_counts,
    output logic                 locked,
    output logic                 error_pulse,
    output logic                 sync_lost,
    output logic [CNT_W-1:0]     bit_count,
    output logic [CNT_W-1:0]     err_count
);
    localparam int FILL_W  = $clog2(WIDTH + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int RUN_W   = $clog2(UNLOCK_ERRS + 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_SYNC,
        ST_LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic               err_pulse_q, err_pulse_d;
    logic               lost_q, lost_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

    logic               pred;
    logic               mismatch;
    logic               bit_inc;
    logic               err_inc;
    logic [WIDTH-1:0]   ref_next;
    logic [CNT_W-1:0]   bit_base;
    logic [CNT_W-1:0]   err_base;

    assign pred     = ^(hist_q & tap_pattern);
    assign mismatch = pred ^ rx.bit_in;
    assign ref_next = {pred, hist_q[WIDTH-1:1]};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        run_d       = run_q;
        err_pulse_d = 1'b0;
        lost_d      = 1'b0;
        bit_inc     = 1'b0;
        err_inc     = 1'b0;

        if (resync) begin
            state_d = ST_FILL;
            hist_d  = '0;
            fill_d  = '0;
            match_d = '0;
            run_d   = '0;
        end else if (rx.bit_valid) begin
            case (state_q)
                ST_FILL: begin
                    hist_d = {rx.bit_in, hist_q[WIDTH-1:1]};
                    if (fill_q == FILL_W'(WIDTH - 1)) begin
                        state_d = ST_SYNC;
                        fill_d  = '0;
                        match_d = '0;
                    end else begin
                        fill_d = fill_q + 1'b1;
                    end
                end
                ST_SYNC: begin
                    hist_d = {rx.bit_in, hist_q[WIDTH-1:1]};
                    // An all-zero history predicts zero trivially, so it never earns credit.
                    if (!mismatch && (hist_q != '0)) begin
                        if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                            state_d = ST_LOCKED;
                            match_d = '0;
                            run_d   = '0;
                        end else begin
                            match_d = match_q + 1'b1;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    // The reference advances on its own prediction so one bad bit costs one error.
                    hist_d  = ref_next;
                    bit_inc = 1'b1;
                    if (mismatch) begin
                        err_inc     = 1'b1;
                        err_pulse_d = 1'b1;
                        run_d       = run_q + 1'b1;
                    end else begin
                        run_d = '0;
                    end
                    if ((mismatch && (run_q == RUN_W'(UNLOCK_ERRS - 1))) || (ref_next == '0)) begin
                        state_d = ST_FILL;
                        hist_d  = '0;
                        fill_d  = '0;
                        run_d   = '0;
                        lost_d  = 1'b1;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    // Clear happens before the increment, so a same-cycle event leaves the count at 1.
    always_comb begin
        bit_base  = clear_counts ? '0 : bit_cnt_q;
        err_base  = clear_counts ? '0 : err_cnt_q;
        bit_cnt_d = (bit_inc && (bit_base != '1)) ? bit_base + 1'b1 : bit_base;
        err_cnt_d = (err_inc && (err_base != '1)) ? err_base + 1'b1 : err_base;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            run_q       <= '0;
            err_pulse_q <= 1'b0;
            lost_q      <= 1'b0;
            bit_cnt_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            run_q       <= run_d;
            err_pulse_q <= err_pulse_d;
            lost_q      <= lost_d;
            bit_cnt_q   <= bit_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign locked      = (state_q == ST_LOCKED);
    assign error_pulse = err_pulse_q;
    assign sync_lost   = lost_q;
    assign bit_count   = bit_cnt_q;
    assign err_count   = err_cnt_q;
endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: acquisition, errors, loss of lock,
// zero stream, gaps, saturation (CNT_W=4 copy), clear and resync.
module tb_lfsr_prbs_checker;
    localparam logic [7:0] TAPS = 8'h71;

    logic        clk = 1'b0;
    logic        rst;
    logic        resync;
    logic        clear_counts;
    logic        locked, error_pulse, sync_lost;
    logic [15:0] bit_count, err_count;
    logic        s_locked, s_error_pulse, s_sync_lost;
    logic [3:0]  s_bit_count, s_err_count;
    logic [7:0]  gen_q;

    int n_cmp = 0;
    int n_bad = 0;

    lfsr_prbs_checker_if rx_if ();

    lfsr_prbs_checker #(.WIDTH(8), .LOCK_COUNT(16), .UNLOCK_ERRS(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst(rst), .rx(rx_if.slave), .tap_pattern(TAPS),
        .resync(resync), .clear_counts(clear_counts),
        .locked(locked), .error_pulse(error_pulse), .sync_lost(sync_lost),
        .bit_count(bit_count), .err_count(err_count)
    );

    lfsr_prbs_checker #(.WIDTH(8), .LOCK_COUNT(16), .UNLOCK_ERRS(4), .CNT_W(4)) u_dut_sat (
        .clk(clk), .rst(rst), .rx(rx_if.slave), .tap_pattern(TAPS),
        .resync(resync), .clear_counts(clear_counts),
        .locked(s_locked), .error_pulse(s_error_pulse), .sync_lost(s_sync_lost),
        .bit_count(s_bit_count), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference generator obeying b[n+8] = ^(taps & b[n..n+7]); gen_q[0] is the oldest bit.
    task automatic next_bit(output logic b);
        b     = gen_q[0];
        gen_q = {^(gen_q & TAPS), gen_q[7:1]};
    endtask

    task automatic cycle(input logic v, input logic b, input logic rs, input logic cl);
        rx_if.bit_valid = v;
        rx_if.bit_in    = b;
        resync          = rs;
        clear_counts    = cl;
        @(posedge clk);
        #1;
        rx_if.bit_valid = 1'b0;
        resync          = 1'b0;
        clear_counts    = 1'b0;
    endtask

    task automatic send(input logic flip, input logic cl);
        logic b;
        next_bit(b);
        cycle(1'b1, b ^ flip, 1'b0, cl);
    endtask

    initial begin
        gen_q           = 8'h01;
        rst             = 1'b1;
        resync          = 1'b0;
        clear_counts    = 1'b0;
        rx_if.bit_valid = 1'b0;
        rx_if.bit_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_locked", locked, 1'b0);
        check("rst_err_pulse", error_pulse, 1'b0);
        check("rst_sync_lost", sync_lost, 1'b0);
        check("rst_bit_count", bit_count, 16'd0);
        check("rst_err_count", err_count, 16'd0);
        rst = 1'b0;

        // Acquisition: 8 fill bits + 16 matches
        for (int i = 1; i <= 24; i++) begin
            send(1'b0, 1'b0);
            check("acq_locked", locked, (i == 24));
            check("acq_bit_count", bit_count, 16'd0);
        end
        check("acq_err_count", err_count, 16'd0);

        // Single error on bit 40
        for (int i = 25; i <= 39; i++) send(1'b0, 1'b0);
        check("pre40_bit_count", bit_count, 16'd15);
        send(1'b1, 1'b0);
        check("b40_err_pulse", error_pulse, 1'b1);
        check("b40_err_count", err_count, 16'd1);
        check("b40_locked", locked, 1'b1);
        check("b40_sync_lost", sync_lost, 1'b0);
        check("b40_bit_count", bit_count, 16'd16);
        for (int i = 41; i <= 50; i++) begin
            send(1'b0, 1'b0);
            check("post40_err_pulse", error_pulse, 1'b0);
        end
        check("post40_err_count", err_count, 16'd1);
        check("post40_bit_count", bit_count, 16'd26);
        check("post40_locked", locked, 1'b1);

        // Clear on an idle cycle, then four consecutive errors drop lock
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("clr_bit_count", bit_count, 16'd0);
        check("clr_err_count", err_count, 16'd0);
        for (int i = 1; i <= 4; i++) begin
            send(1'b1, 1'b0);
            check("run_err_pulse", error_pulse, 1'b1);
            check("run_sync_lost", sync_lost, (i == 4));
            check("run_locked", locked, (i != 4));
        end
        check("run_err_count", err_count, 16'd4);
        check("run_bit_count", bit_count, 16'd4);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        check("idle_sync_lost", sync_lost, 1'b0);
        check("idle_err_pulse", error_pulse, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            send(1'b0, 1'b0);
            check("relock_locked", locked, (i == 24));
        end
        check("relock_bit_count", bit_count, 16'd4);
        check("relock_err_count", err_count, 16'd4);

        // Resync while locked (bit presented with it is discarded)
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("rsy_locked", locked, 1'b0);
        check("rsy_sync_lost", sync_lost, 1'b0);
        check("rsy_err_pulse", error_pulse, 1'b0);
        check("rsy_bit_count", bit_count, 16'd4);
        check("rsy_err_count", err_count, 16'd4);

        // All-zero stream must never lock
        for (int i = 1; i <= 100; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0);
            check("zero_locked", locked, 1'b0);
        end
        check("zero_bit_count", bit_count, 16'd4);

        // Gapped clean stream: latency still 24 valid bits
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 24; i++) begin
            send(1'b0, 1'b0);
            check("gap_locked", locked, (i == 24));
            if (i % 2 == 1) begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                check("gap_idle_locked", locked, 1'b0);
                check("gap_idle_err_pulse", error_pulse, 1'b0);
            end
        end
        check("gap_bit_count", bit_count, 16'd4);

        // Clear in the same cycle as an error
        send(1'b1, 1'b1);
        check("clr_ev_err_count", err_count, 16'd1);
        check("clr_ev_bit_count", bit_count, 16'd1);
        check("clr_ev_err_pulse", error_pulse, 1'b1);
        check("clr_ev_sat_err", s_err_count, 4'd1);
        send(1'b0, 1'b0);

        // 20 isolated errors: CNT_W=4 copy saturates at 15
        for (int i = 1; i <= 20; i++) begin
            send(1'b1, 1'b0);
            check("sat_err_count", s_err_count, ((i + 1) > 15) ? 4'd15 : 4'(i + 1));
            send(1'b0, 1'b0);
        end
        check("sat_bit_count", s_bit_count, 4'd15);
        check("sat_locked", s_locked, 1'b1);
        check("wide_err_count", err_count, 16'd21);
        check("wide_bit_count", bit_count, 16'd42);
        check("wide_locked", locked, 1'b1);

        // Resync and clear together
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("rsyclr_locked", locked, 1'b0);
        check("rsyclr_sync_lost", sync_lost, 1'b0);
        check("rsyclr_bit_count", bit_count, 16'd0);
        check("rsyclr_err_count", err_count, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/lfsr_prbs_checker.md
# lfsr_prbs_checker

Downstream consumer of the configurable LFSR's `serial_out` stream. Uses the same `tap_pattern` to self-synchronise to the incoming pseudo-random bit sequence and declare lock. Once locked, it free-runs a local reference and counts received bits and bit errors. It is the receive-side measurement stage for PRBS link and loopback testing.

## Interface
- `WIDTH`, default 8: LFSR length; must equal the generator's width.
- `LOCK_COUNT`, default 16: consecutive correct predictions required to lock (≥1).
- `UNLOCK_ERRS`, default 4: consecutive mismatches while locked that drop lock (≥1).
- `CNT_W`, default 16: width of the bit and error counters.

- `clk` input 1: single clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `bit_valid` input 1: `bit_in` is valid this cycle.
- `bit_in` input 1: received serial bit, connected to the LFSR `serial_out`.
- `tap_pattern` input WIDTH: same feedback taps as the generator. Static while `locked`.
- `resync` input 1: one-cycle pulse; forces re-acquisition.
- `clear_counts` input 1: one-cycle pulse; zeroes both counters.
- `locked` output 1: checker is synchronised.
- `error_pulse` output 1: one-cycle pulse per mismatched bit while locked.
- `sync_lost` output 1: one-cycle pulse when lock is dropped.
- `bit_count` output CNT_W: valid bits received while locked, saturating.
- `err_count` output CNT_W: errors while locked, saturating.

## Operation
- Generator relation: stream bits b_n obey b_{n+WIDTH} = XOR over k of (tap_pattern[k] & b_{n+k}).
- History register `hist` (WIDTH bits). A shift is `hist <= {x, hist[WIDTH-1:1]}`, so `hist[WIDTH-1]` is the newest bit.
- Prediction: `pred = ^(hist & tap_pattern)`, compared against `bit_in`.
- States: FILL, SYNC, LOCKED. Transitions happen only on cycles with `bit_valid`, except reset and `resync`.
- FILL:
  - Shift `bit_in` into `hist`; count bits.
  - After WIDTH bits, go to SYNC with the match counter at 0.
- SYNC:
  - Shift `bit_in` into `hist`.
  - `pred == bit_in` with `hist` non-zero: match counter +1.
  - Mismatch, or `hist` all-zero: match counter resets to 0. An all-zero history never qualifies for lock.
  - Match counter reaching LOCK_COUNT: go to LOCKED and assert `locked`.
- LOCKED:
  - Shift `pred` (not `bit_in`) into `hist`, so a single bit error counts exactly once.
  - Every valid bit: `bit_count` +1.
  - Mismatch: `err_count` +1, `error_pulse` = 1, run counter +1.
  - Match: run counter resets to 0.
  - Run counter reaching UNLOCK_ERRS: go to FILL, clear `hist`, deassert `locked`, pulse `sync_lost`.
  - Reference `hist` becoming all-zero: same exit as above.
- Counters saturate at 2^CNT_W−1 and never wrap. They hold their values across loss of lock and are cleared only by `clear_counts` or `rst`.
- Invalid cycles (`bit_valid` = 0): no state, history or counter change; pulse outputs are 0.

## Timing
- All outputs are registered. Response to a bit presented in cycle t is visible in cycle t+1.
- Lock latency: `locked` rises the cycle after the (WIDTH+LOCK_COUNT)-th valid bit of a clean, non-zero stream (24 bits at defaults).
- `error_pulse` and `sync_lost` are exactly one cycle wide. On the unlocking error, both pulse in the same cycle and that error is counted.
- Reset values: state FILL, `hist` = 0, all internal counters 0, `locked` = 0, `error_pulse` = 0, `sync_lost` = 0, `bit_count` = 0, `err_count` = 0.
- `rst` overrides everything.
- `resync` overrides `bit_valid`:
  - The bit in that cycle is discarded; go to FILL and clear `hist`.
  - `locked` drops next cycle with no `sync_lost` pulse.
  - Counters are kept.
- `clear_counts` together with a counted event in the same cycle: clear first, then apply the increment. The result is 1.
- `resync` and `clear_counts` together: both take effect.
- `tap_pattern` changes while locked are illegal; software must follow any change with `resync`.

## Test plan
- Reset, then drive an LFSR model (taps 0x71, seed 0x01) with continuous `bit_valid`. Required: `locked` = 0 through bit 24, `locked` = 1 the cycle after bit 24, counters 0 beforehand.
- Locked stream with bit 40 inverted. Required: one `error_pulse` the cycle after bit 40, `err_count` = 1, `locked` stays 1, `bit_count` keeps incrementing with no further errors.
- Four consecutive inverted bits while locked. Required: `err_count` = 4, `sync_lost` pulses with the 4th `error_pulse`, `locked` = 0, relock exactly 24 valid bits later.
- All-zero stream for 100 bits, then `bit_valid` gaps inserted into a clean stream. Required: never locks on zeros; gaps do not change lock latency measured in valid bits.
- CNT_W = 4 with 20 isolated errors. Required: `err_count` saturates at 15.
- `clear_counts` in the same cycle as an error. Required: `err_count` = 1.
- `resync` while locked. Required: `locked` = 0 next cycle, no `sync_lost` pulse, counters unchanged.
